// File: rtl/deserializer_align.sv
// Serial-to-parallel receiver with comma-based word alignment; optional loss-of-lock detection via DESER_LOSS_DET_EN.
// All outputs registered: a word's last bit sampled at edge k appears on data_out/valid (or comma_det) after edge k.
module deserializer_align #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] COMMA = WIDTH'(8'hBC),
  parameter int LOCK_CNT = 4,
  parameter int MAX_GAP = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             din,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             locked,
  output logic             comma_det,
  output logic             sync_err
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam int GW = $clog2(MAX_GAP + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [CW-1:0] LOCK_N   = CW'(LOCK_CNT);
  localparam logic [GW-1:0] GAP_N    = GW'(MAX_GAP);

  typedef enum logic [1:0] {S_HUNT, S_ALIGN, S_LOCKED} state_t;

  state_t           r_state, w_state_nxt;
  // Only the newest WIDTH-1 bits are kept; the oldest bit falls out as din shifts in.
  logic [WIDTH-2:0] r_shreg;
  logic [BW-1:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [CW-1:0]    r_comma_cnt, w_comma_cnt_nxt;
  logic [GW-1:0]    r_gap_cnt, w_gap_cnt_nxt, w_gap_inc;
  logic [WIDTH-1:0] r_data, w_data_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_locked, w_locked_nxt;
  logic             r_comma_det, w_comma_det_nxt;
  logic             r_sync_err, w_sync_err_nxt;

  logic [WIDTH-1:0] w_new;
  logic             w_is_comma;
  logic             w_word_done;

  assign w_new       = {din, r_shreg};
  assign w_is_comma  = (w_new == COMMA);
  assign w_word_done = enb && (r_bit_cnt == LAST_BIT);
  assign w_gap_inc   = (r_gap_cnt == GAP_N) ? r_gap_cnt : r_gap_cnt + GW'(1);

  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_comma_cnt_nxt = r_comma_cnt;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_data_nxt      = r_data;
    w_locked_nxt    = r_locked;
    w_valid_nxt     = 1'b0;
    w_comma_det_nxt = 1'b0;
    w_sync_err_nxt  = 1'b0;
    if (enb) begin
      w_bit_cnt_nxt = w_word_done ? '0 : r_bit_cnt + BW'(1);
      unique case (r_state)
        S_HUNT: begin
          // Every enabled bit is a candidate boundary while hunting.
          if (w_is_comma) begin
            w_bit_cnt_nxt   = '0;
            w_comma_cnt_nxt = CW'(1);
            w_gap_cnt_nxt   = '0;
            w_comma_det_nxt = 1'b1;
            if (LOCK_CNT > 1) begin
              w_state_nxt = S_ALIGN;
            end else begin
              w_state_nxt  = S_LOCKED;
              w_locked_nxt = 1'b1;
            end
          end
        end
        S_ALIGN: begin
          if (w_word_done) begin
            if (w_is_comma) begin
              w_comma_cnt_nxt = r_comma_cnt + CW'(1);
              w_comma_det_nxt = 1'b1;
              if (r_comma_cnt + CW'(1) == LOCK_N) begin
                w_state_nxt   = S_LOCKED;
                w_locked_nxt  = 1'b1;
                w_gap_cnt_nxt = '0;
              end
            end else begin
              w_state_nxt     = S_HUNT;
              w_comma_cnt_nxt = '0;
            end
          end
        end
        S_LOCKED: begin
          if (w_word_done) begin
            if (w_is_comma) begin
              w_comma_det_nxt = 1'b1;
              w_gap_cnt_nxt   = '0;
            end else
`ifdef DESER_LOSS_DET_EN
            if (w_gap_inc == GAP_N) begin
              w_state_nxt     = S_HUNT;
              w_locked_nxt    = 1'b0;
              w_sync_err_nxt  = 1'b1;
              w_comma_cnt_nxt = '0;
              w_gap_cnt_nxt   = '0;
            end else
`endif
            begin
              w_data_nxt    = w_new;
              w_valid_nxt   = 1'b1;
              w_gap_cnt_nxt = w_gap_inc;
            end
          end
        end
        default: w_state_nxt = S_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_HUNT;
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_comma_cnt <= '0;
      r_gap_cnt   <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_locked    <= 1'b0;
      r_comma_det <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      if (enb) r_shreg <= w_new[WIDTH-1:1];
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_comma_cnt <= w_comma_cnt_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_data      <= w_data_nxt;
      r_valid     <= w_valid_nxt;
      r_locked    <= w_locked_nxt;
      r_comma_det <= w_comma_det_nxt;
      r_sync_err  <= w_sync_err_nxt;
    end
  end

  assign data_out  = r_data;
  assign valid     = r_valid;
  assign locked    = r_locked;
  assign comma_det = r_comma_det;
  assign sync_err  = r_sync_err;

endmodule

// File: tb/tb_deserializer_align.sv
// Bench for deserializer_align: vector table, hand-written corner sequences and a random stream vs a reference model.
module tb_deserializer_align;

  localparam int LOCK_N  = 4;
  localparam int GAP_MAX = 4;
`ifdef DESER_LOSS_DET_EN
  localparam bit LOSS = 1'b1;
`else
  localparam bit LOSS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, enb, din;
  logic [7:0] data_out;
  logic       valid, locked, comma_det, sync_err;

  deserializer_align #(
    .WIDTH(8), .COMMA(8'hBC), .LOCK_CNT(LOCK_N), .MAX_GAP(GAP_MAX)
  ) dut (
    .clk(clk), .rst(rst), .enb(enb), .din(din),
    .data_out(data_out), .valid(valid), .locked(locked),
    .comma_det(comma_det), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cnt_v, cnt_cd, cnt_se, cnt_low;

  // Reference model: a sliding window of the last 8 received bits and a
  // count of bits received since the last accepted boundary.
  int         m_mode;   // 0 hunting, 1 confirming, 2 locked
  int         m_since;
  int         m_commas;
  int         m_gap;
  logic [7:0] m_win;
  logic [7:0] e_data;
  bit         e_valid, e_lock, e_cd, e_se;

  function automatic void model_reset();
    m_mode = 0; m_since = 0; m_commas = 0; m_gap = 0; m_win = 8'h00;
    e_data = 8'h00; e_valid = 0; e_lock = 0; e_cd = 0; e_se = 0;
  endfunction

  function automatic void model_bit(input bit en, input bit d);
    e_valid = 0; e_cd = 0; e_se = 0;
    if (!en) return;
    m_win = {d, m_win[7:1]};
    if (m_mode == 0) begin
      if (m_win == 8'hBC) begin
        m_since = 0; m_commas = 1; e_cd = 1;
        if (LOCK_N > 1) m_mode = 1;
        else begin m_mode = 2; e_lock = 1; m_gap = 0; end
      end
      return;
    end
    m_since++;
    if (m_since < 8) return;
    m_since = 0;
    if (m_mode == 1) begin
      if (m_win == 8'hBC) begin
        m_commas++; e_cd = 1;
        if (m_commas == LOCK_N) begin m_mode = 2; e_lock = 1; m_gap = 0; end
      end else begin
        m_mode = 0; m_commas = 0;
      end
    end else begin
      if (m_win == 8'hBC) begin
        e_cd = 1; m_gap = 0;
      end else begin
        m_gap++;
        if (LOSS && m_gap >= GAP_MAX) begin
          m_mode = 0; e_lock = 0; e_se = 1; m_gap = 0; m_commas = 0;
        end else begin
          e_data = m_win; e_valid = 1;
        end
      end
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clr();
    cnt_v = 0; cnt_cd = 0; cnt_se = 0; cnt_low = 0;
  endtask

  task automatic tick(input bit en, input bit d);
    enb = en; din = d;
    @(posedge clk);
    model_bit(en, d);
    #1;
    check("cycle {data,valid,locked,comma_det,sync_err}",
          int'({data_out, valid, locked, comma_det, sync_err}),
          int'({e_data, e_valid, e_lock, e_cd, e_se}));
    cnt_v  += int'(valid);
    cnt_cd += int'(comma_det);
    cnt_se += int'(sync_err);
    if (!en) cnt_low += int'(valid | comma_det | sync_err);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) tick(1'b1, w[i]);
  endtask

  typedef struct {
    logic [7:0] word;
    bit         v;
    bit         cd;
    logic [7:0] data;
  } vec_t;
  vec_t tbl[6];

  logic [7:0] kw;
  logic [7:0] aw;
  logic [7:0] rw;

  initial begin
    tbl[0] = '{8'hBC, 1'b0, 1'b1, 8'h5A};
    tbl[1] = '{8'h3C, 1'b1, 1'b0, 8'h3C};
    tbl[2] = '{8'hA5, 1'b1, 1'b0, 8'hA5};
    tbl[3] = '{8'hBC, 1'b0, 1'b1, 8'hA5};
    tbl[4] = '{8'h5A, 1'b1, 1'b0, 8'h5A};
    tbl[5] = '{8'hBC, 1'b0, 1'b1, 8'h5A};
    kw = 8'hBC;
    aw = 8'hA5;

    rst = 1'b0; enb = 1'b0; din = 1'b0;
    model_reset(); clr();
    #2 rst = 1'b1;
    #10;
    check("reset data_out", int'(data_out), 0);
    check("reset valid", int'(valid), 0);
    check("reset locked", int'(locked), 0);
    check("reset comma_det", int'(comma_det), 0);
    check("reset sync_err", int'(sync_err), 0);
    #1 rst = 1'b0;

    // Lock at a 3-bit offset; locked must rise on the 32nd comma bit.
    repeat (3) tick(1'b1, 1'b1);
    clr();
    repeat (3) send_word(kw);
    for (int i = 0; i < 7; i++) tick(1'b1, kw[i]);
    check("locked before last comma bit", int'(locked), 0);
    tick(1'b1, kw[7]);
    check("locked on last comma bit", int'(locked), 1);
    check("comma_det pulses to lock", cnt_cd, 4);
    send_word(8'h5A);
    check("first word {valid,data}", int'({valid, data_out}), int'({1'b1, 8'h5A}));
    tick(1'b0, 1'b0);
    check("valid drops after one cycle", int'(valid), 0);

    for (int i = 0; i < 6; i++) begin
      send_word(tbl[i].word);
      check($sformatf("table row %0d {valid,comma_det,data}", i),
            int'({valid, comma_det, data_out}), int'({tbl[i].v, tbl[i].cd, tbl[i].data}));
    end

    // Enable gated low for 5 cycles mid-word.
    clr();
    for (int i = 0; i < 4; i++) tick(1'b1, aw[i]);
    repeat (5) tick(1'b0, 1'($urandom));
    for (int i = 4; i < 8; i++) tick(1'b1, aw[i]);
    check("gated word data", int'(data_out), 8'hA5);
    check("gated word valid count", cnt_v, 1);
    check("strobes while enb low", cnt_low, 0);

    // Four data words in a row after a comma.
    send_word(kw);
    clr();
    send_word(8'h11); send_word(8'h12); send_word(8'h13); send_word(8'h14);
    check("gap valid count", cnt_v, LOSS ? 3 : 4);
    check("gap sync_err count", cnt_se, LOSS ? 1 : 0);
    check("gap locked", int'(locked), LOSS ? 0 : 1);
    check("gap last data", int'(data_out), LOSS ? 8'h13 : 8'h14);

    // Asynchronous reset in the middle of a word.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
    #3 rst = 1'b1;
    #1;
    check("async reset outputs", int'({data_out, valid, locked, comma_det, sync_err}), 0);
    model_reset(); clr();
    repeat (2) begin
      @(posedge clk); #1;
      check("reset held outputs", int'({data_out, valid, locked, comma_det, sync_err}), 0);
    end
    rst = 1'b0;

    // Alignment broken by a non-comma word, then a clean lock.
    send_word(kw); send_word(kw); send_word(8'h00);
    check("break comma_det count", cnt_cd, 2);
    check("break valid count", cnt_v, 0);
    check("break locked", int'(locked), 0);
    check("break sync_err count", cnt_se, 0);
    clr();
    repeat (4) send_word(kw);
    check("relock comma_det count", cnt_cd, 4);
    check("relock locked", int'(locked), 1);

    // Random word stream with idle cycles and occasional bit slips.
    for (int w = 0; w < 300; w++) begin
      rw = ($urandom_range(0, 2) == 0) ? kw : 8'($urandom);
      if ($urandom_range(0, 39) == 0) tick(1'b1, 1'($urandom));
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 4) == 0) tick(1'b0, 1'($urandom));
        tick(1'b1, rw[i]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/deserializer_align.md
# deserializer_align

Receive-side deserializer with comma-based word alignment. Consumes the LSB-first serial bit stream produced by the transmit serializer and reassembles WIDTH-bit words. Hunts for a comma character to find word boundaries, confirms alignment over several consecutive commas, then delivers data words with a one-cycle valid strobe to the downstream receive logic.

## Interface

- WIDTH, 8, word width in bits (≥4)
- COMMA, 8'hBC, alignment character, WIDTH bits, must be nonzero
- LOCK_CNT, 4, consecutive aligned commas required to declare lock (≥1)
- MAX_GAP, 16, max consecutive non-comma words while locked (used only with loss detection)

- clk  input  1  clock; all logic on posedge
- rst  input  1  reset, asynchronous, active-high
- enb  input  1  bit-enable; din sampled and state advanced only when 1
- din  input  1  serial data, LSB first
- data_out  output  WIDTH  last delivered data word, registered
- valid  output  1  one-cycle strobe, data_out holds a new word
- locked  output  1  high while in LOCKED
- comma_det  output  1  one-cycle strobe on each comma detection
- sync_err  output  1  one-cycle strobe on loss of lock

## Operation

- Shift register: on enb=1, shreg <= {din, shreg[WIDTH-1:1]}; "new word" denotes this next-state value.
- Bit counter bit_cnt, 0..WIDTH-1, advances on enb=1, wraps to 0; word complete when enb=1 and bit_cnt==WIDTH-1.
- States: HUNT, ALIGN, LOCKED.
- HUNT: every enb cycle compare new word to COMMA. On match: bit_cnt<=0, comma_cnt<=1, comma_det pulse; go ALIGN if LOCK_CNT>1, else LOCKED.
- ALIGN: at word complete, new word==COMMA: comma_cnt+1, comma_det pulse; on reaching LOCK_CNT go LOCKED, locked<=1 same edge. Non-comma word: go HUNT, comma_cnt<=0, no valid, no sync_err.
- LOCKED: at word complete, comma word: comma_det pulse, no valid, gap_cnt<=0. Non-comma word: data_out<=new word, valid pulse, gap_cnt+1 (saturating).
- bit_cnt ignored in HUNT (comparison on every enabled bit).
- enb=0: shreg, bit_cnt, counters, state, data_out hold; valid, comma_det, sync_err low.
- Strobes never exceed one cycle; valid and comma_det mutually exclusive.
- Reset mid-operation: asynchronous return to HUNT, all outputs cleared immediately; partial word discarded.

## Timing

- Reset values: data_out=0, valid=0, locked=0, comma_det=0, sync_err=0; shreg=0, bit_cnt=0, comma_cnt=0, gap_cnt=0, state HUNT.
- All outputs registered. Latency: last bit of a word sampled at edge k → data_out/valid (or comma_det) valid in cycle after edge k.
- Lock: locked rises at the edge sampling the last bit of the LOCK_CNT-th aligned comma.
- Worst-case word rate: one word per WIDTH enabled cycles; back-to-back enb=1 gives valid every WIDTH cycles.

## Configuration

- DESER_LOSS_DET_EN defined: in LOCKED, a non-comma word that brings gap_cnt to MAX_GAP is not delivered (valid stays 0); same edge: state HUNT, locked<=0, sync_err pulses one cycle, counters cleared.
- Not defined: gap_cnt and MAX_GAP unused; LOCKED left only via rst; sync_err tied 0.

## Test plan

- Reset: assert rst mid-stream → all outputs 0 asynchronously, before next clk edge; held with rst high.
- Lock at offset: 3 junk bits, then four 0xBC LSB-first, enb=1 → comma_det pulses 4 times, locked=1 after 4th comma's last bit; then 0x5A → data_out=0x5A, valid high one cycle, one clk after its 8th bit.
- Alignment break: two 0xBC then 0x00 → state HUNT, locked stays 0, no valid; subsequent four 0xBC lock correctly.
- enb gating: locked, send 0xA5 with enb low 5 cycles after bit 3 → data_out=0xA5, valid exactly once, no strobes while enb low.
- Loss detection, MAX_GAP=4: locked, four non-comma words 0x11..0x14 → valid for 0x11..0x13 only, sync_err pulse on 0x14, locked=0; without DESER_LOSS_DET_EN all four delivered, locked stays 1.
- Comma while locked: 0x5A, 0xBC, 0x3C → valid for 0x5A and 0x3C, comma_det for 0xBC, data_out holds 0x5A across the comma word.
